// File: rtl/ring_rx.sv
// Serial ring receiver: deframes start/ID/ADDR/[DATA]/[PAR]/stop into a one-deep holding register.
// Define RING_RX_PARITY_EN to add the even-parity bit and Parity_Err detection.
module ring_rx #(
    parameter int DATA_W = 24
) (
    input  logic              Clk_S,
    input  logic              Rst_n,
    input  logic              S_Data_in,
    input  logic [3:0]        r_addr,
    input  logic              Pkt_Ready,
    output logic              Pkt_Valid,
    output logic [2:0]        Pkt_ID,
    output logic [3:0]        Pkt_Addr,
    output logic [DATA_W-1:0] Pkt_Data,
    output logic              Addr_Match,
    output logic              Frame_Err,
    output logic              Parity_Err,
    output logic              Overrun
);

    localparam logic [2:0] ID_DATA_C = 3'b010;
    localparam logic [2:0] ID_DATA_3 = 3'b001;

    typedef enum logic [2:0] {S_IDLE, S_ID, S_ADDR, S_DATA, S_PAR, S_STOP} state_t;

`ifdef RING_RX_PARITY_EN
    localparam state_t POST_FIELDS = S_PAR;
`else
    localparam state_t POST_FIELDS = S_STOP;
`endif

    state_t            state;
    logic [4:0]        cnt;
    logic [2:0]        id_sh;
    logic [3:0]        addr_sh;
    logic [DATA_W-1:0] data_sh;
`ifdef RING_RX_PARITY_EN
    logic              par_acc;
`endif

    logic [2:0] id_next;
    logic       id_ok;
    logic       has_data;

    assign id_next    = {id_sh[1:0], S_Data_in};
    assign id_ok      = (id_next != 3'b100) && (id_next != 3'b101) && (id_next != 3'b110);
    assign has_data   = (id_sh == ID_DATA_C) || (id_sh == ID_DATA_3);
    assign Addr_Match = Pkt_Valid && (Pkt_Addr == r_addr);

    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            id_sh      <= '0;
            addr_sh    <= '0;
            data_sh    <= '0;
`ifdef RING_RX_PARITY_EN
            par_acc    <= 1'b0;
`endif
            Pkt_Valid  <= 1'b0;
            Pkt_ID     <= '0;
            Pkt_Addr   <= '0;
            Pkt_Data   <= '0;
            Frame_Err  <= 1'b0;
            Parity_Err <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            Frame_Err  <= 1'b0;
            Parity_Err <= 1'b0;
            Overrun    <= 1'b0;

            // A load in STOP below overrides this clear (consume + complete in one cycle).
            if (Pkt_Valid && Pkt_Ready)
                Pkt_Valid <= 1'b0;

`ifdef RING_RX_PARITY_EN
            if (state == S_ID || state == S_ADDR || state == S_DATA)
                par_acc <= par_acc ^ S_Data_in;
`endif

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (S_Data_in) begin
                        state   <= S_ID;
                        cnt     <= 5'd2;
                        data_sh <= '0;
`ifdef RING_RX_PARITY_EN
                        par_acc <= 1'b0;
`endif
                    end
                end
                S_ID: begin
                    id_sh <= id_next;
                    if (cnt == 5'd0) begin
                        if (id_ok) begin
                            state <= S_ADDR;
                            cnt   <= 5'd3;
                        end else begin
                            Frame_Err <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_ADDR: begin
                    addr_sh <= {addr_sh[2:0], S_Data_in};
                    if (cnt == 5'd0) begin
                        if (has_data) begin
                            state <= S_DATA;
                            cnt   <= 5'(DATA_W - 1);
                        end else begin
                            state <= POST_FIELDS;
                        end
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_DATA: begin
                    data_sh <= {data_sh[DATA_W-2:0], S_Data_in};
                    if (cnt == 5'd0)
                        state <= POST_FIELDS;
                    else
                        cnt <= cnt - 5'd1;
                end
`ifdef RING_RX_PARITY_EN
                S_PAR: begin
                    cnt <= '0;
                    if (par_acc ^ S_Data_in) begin
                        Parity_Err <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    if (S_Data_in) begin
                        Frame_Err <= 1'b1;
                    end else if (!Pkt_Valid || Pkt_Ready) begin
                        Pkt_Valid <= 1'b1;
                        Pkt_ID    <= id_sh;
                        Pkt_Addr  <= addr_sh;
                        Pkt_Data  <= data_sh;
                    end else begin
                        Overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_rx.sv
// Directed bench for ring_rx with a packet scoreboard; follows RING_RX_PARITY_EN when defined.
module tb_ring_rx;

    localparam int DATA_W = 24;
    localparam logic [2:0] TOKEN = 3'b111, ACK = 3'b000, NACK = 3'b011, DATA_C = 3'b010, DATA_3 = 3'b001;

    logic              Clk_S = 1'b0;
    logic              Rst_n;
    logic              S_Data_in;
    logic [3:0]        r_addr;
    logic              Pkt_Ready;
    logic              Pkt_Valid;
    logic [2:0]        Pkt_ID;
    logic [3:0]        Pkt_Addr;
    logic [DATA_W-1:0] Pkt_Data;
    logic              Addr_Match;
    logic              Frame_Err;
    logic              Parity_Err;
    logic              Overrun;

    ring_rx #(.DATA_W(DATA_W)) dut (
        .Clk_S(Clk_S), .Rst_n(Rst_n), .S_Data_in(S_Data_in), .r_addr(r_addr),
        .Pkt_Ready(Pkt_Ready), .Pkt_Valid(Pkt_Valid), .Pkt_ID(Pkt_ID), .Pkt_Addr(Pkt_Addr),
        .Pkt_Data(Pkt_Data), .Addr_Match(Addr_Match), .Frame_Err(Frame_Err),
        .Parity_Err(Parity_Err), .Overrun(Overrun)
    );

    always #5 Clk_S = ~Clk_S;

    typedef struct {
        logic [2:0]        id;
        logic [3:0]        addr;
        logic [DATA_W-1:0] data;
        logic              match;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int fe_n = 0, pe_n = 0, ov_n = 0, vcyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge Clk_S);
        S_Data_in = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_bit(1'b0);
    endtask

    // Everything except the stop bit; flip >= 0 inverts that data bit after parity is computed.
    task automatic send_head(input logic [2:0] id, input logic [3:0] addr,
                             input logic [DATA_W-1:0] data, input int flip);
        logic p;
        p = ^{id, addr};
        drive_bit(1'b1);
        for (int i = 2; i >= 0; i--) drive_bit(id[i]);
        for (int i = 3; i >= 0; i--) drive_bit(addr[i]);
        if (id == DATA_C || id == DATA_3) begin
            p = p ^ (^data);
            for (int i = DATA_W - 1; i >= 0; i--) drive_bit(data[i] ^ (flip == i));
        end
`ifdef RING_RX_PARITY_EN
        drive_bit(p);
`endif
    endtask

    task automatic send_frame(input logic [2:0] id, input logic [3:0] addr,
                              input logic [DATA_W-1:0] data, input int flip, input logic stop_bit);
        send_head(id, addr, data, flip);
        drive_bit(stop_bit);
    endtask

    task automatic push(input logic [2:0] id, input logic [3:0] addr, input logic [DATA_W-1:0] data);
        exp_t e;
        e.id = id; e.addr = addr; e.data = data; e.match = (addr == r_addr);
        sb.push_back(e);
    endtask

    // Monitor: settles after negedge-driven inputs, well before the next rising edge.
    always @(negedge Clk_S) begin
        #3;
        if (Rst_n === 1'b1) begin
            if (Frame_Err)  fe_n++;
            if (Parity_Err) pe_n++;
            if (Overrun)    ov_n++;
            if (Pkt_Valid)  vcyc++;
            if (Frame_Err || Parity_Err || Overrun)
                chk("pulse_exclusive", 32'(Frame_Err) + 32'(Parity_Err) + 32'(Overrun), 32'd1);
            if (Pkt_Valid && Pkt_Ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_pkt", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_id",    32'(Pkt_ID),     32'(e.id));
                    chk("sb_addr",  32'(Pkt_Addr),   32'(e.addr));
                    chk("sb_data",  32'(Pkt_Data),   32'(e.data));
                    chk("sb_match", 32'(Addr_Match), 32'(e.match));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int fe0, pe0, ov0, v0;
        Rst_n = 1'b0; S_Data_in = 1'b0; Pkt_Ready = 1'b0; r_addr = 4'd2;
        repeat (3) @(negedge Clk_S);
        #1;
        chk("rst_valid", 32'(Pkt_Valid), 32'd0);
        chk("rst_id",    32'(Pkt_ID),    32'd0);
        chk("rst_addr",  32'(Pkt_Addr),  32'd0);
        chk("rst_data",  32'(Pkt_Data),  32'd0);
        chk("rst_errs",  32'({Frame_Err, Parity_Err, Overrun}), 32'd0);
        @(negedge Clk_S); Rst_n = 1'b1;
        idle(2);

        // DATA_3 to our address, held with Pkt_Ready low
        push(DATA_3, 4'd2, 24'd1234);
        send_frame(DATA_3, 4'd2, 24'd1234, -1, 1'b0);
        #3 chk("d3_valid_pre", 32'(Pkt_Valid), 32'd0);
        @(posedge Clk_S); #1;
        chk("d3_valid_lat1", 32'(Pkt_Valid),  32'd1);
        chk("d3_id",         32'(Pkt_ID),     32'b001);
        chk("d3_data",       32'(Pkt_Data),   32'h0004D2);
        chk("d3_match",      32'(Addr_Match), 32'd1);
        idle(3);
        #1;
        chk("d3_held_valid", 32'(Pkt_Valid), 32'd1);
        chk("d3_held_data",  32'(Pkt_Data),  32'h0004D2);
        @(negedge Clk_S); Pkt_Ready = 1'b1;
        @(negedge Clk_S); Pkt_Ready = 1'b0;
        #1 chk("d3_cleared", 32'(Pkt_Valid), 32'd0);

        // TOKEN to address 0 with Pkt_Ready high: one-cycle valid
        @(negedge Clk_S); r_addr = 4'd1; Pkt_Ready = 1'b1;
        v0 = vcyc;
        push(TOKEN, 4'd0, '0);
        send_frame(TOKEN, 4'd0, '0, -1, 1'b0);
        idle(4);
        chk("tok_valid_cycles", 32'(vcyc - v0), 32'd1);

        // Back-to-back ACKs while full: second dropped with one Overrun
        @(negedge Clk_S); Pkt_Ready = 1'b0;
        ov0 = ov_n;
        push(ACK, 4'd1, '0);
        send_frame(ACK, 4'd1, '0, -1, 1'b0);
        send_frame(ACK, 4'd9, '0, -1, 1'b0);
        idle(3);
        #4;
        chk("ovr_pulse_count", 32'(ov_n - ov0), 32'd1);
        chk("ovr_held_valid",  32'(Pkt_Valid),  32'd1);
        chk("ovr_held_id",     32'(Pkt_ID),     32'b000);
        chk("ovr_held_addr",   32'(Pkt_Addr),   32'd1);
        @(negedge Clk_S); Pkt_Ready = 1'b1;
        @(negedge Clk_S); Pkt_Ready = 1'b0;

        // Unknown ID 101, then a good NACK
        @(negedge Clk_S); Pkt_Ready = 1'b1;
        fe0 = fe_n; v0 = vcyc;
        drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        idle(4);
        chk("badid_frame_err", 32'(fe_n - fe0), 32'd1);
        chk("badid_no_valid",  32'(vcyc - v0),  32'd0);
        push(NACK, 4'd7, '0);
        send_frame(NACK, 4'd7, '0, -1, 1'b0);
        idle(3);
        chk("nack_consumed", 32'(sb.size()), 32'd0);

        // Corrupted DATA_C frame
        fe0 = fe_n; pe0 = pe_n; v0 = vcyc;
`ifdef RING_RX_PARITY_EN
        send_frame(DATA_C, 4'd3, 24'hA5A5A5, 10, 1'b0);
        idle(4);
        chk("flip_parity_err", 32'(pe_n - pe0), 32'd1);
        chk("flip_no_frame",   32'(fe_n - fe0), 32'd0);
`else
        send_frame(DATA_C, 4'd3, 24'hA5A5A5, 10, 1'b1);
        idle(4);
        chk("stop1_frame_err", 32'(fe_n - fe0), 32'd1);
        chk("stop1_no_parity", 32'(pe_n - pe0), 32'd0);
`endif
        chk("bad_no_valid", 32'(vcyc - v0), 32'd0);

        // Completion in the same cycle as consumption of the held packet
        @(negedge Clk_S); Pkt_Ready = 1'b0;
        ov0 = ov_n;
        push(ACK, 4'd6, '0);
        send_frame(ACK, 4'd6, '0, -1, 1'b0);
        idle(2);
        push(DATA_C, 4'd1, 24'hC0FFEE);
        send_head(DATA_C, 4'd1, 24'hC0FFEE, -1);
        @(negedge Clk_S); S_Data_in = 1'b0; Pkt_Ready = 1'b1;
        @(negedge Clk_S); Pkt_Ready = 1'b0;
        #4;
        chk("swap_valid",   32'(Pkt_Valid),      32'd1);
        chk("swap_id",      32'(Pkt_ID),         32'(DATA_C));
        chk("swap_no_ovr",  32'(ov_n - ov0),     32'd0);
        @(negedge Clk_S); Pkt_Ready = 1'b1;
        @(negedge Clk_S); Pkt_Ready = 1'b0;

        // Reset during DATA bit 10 with a packet held
        send_frame(ACK, 4'd4, '0, -1, 1'b0);
        idle(1);
        begin
            logic [DATA_W-1:0] d;
            d = 24'h123456;
            drive_bit(1'b1);
            for (int i = 2; i >= 0; i--) drive_bit(DATA_C[i]);
            for (int i = 3; i >= 0; i--) drive_bit(1'(4'd1 >> i));
            for (int i = DATA_W - 1; i >= 10; i--) drive_bit(d[i]);
        end
        @(posedge Clk_S); #1 Rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(Pkt_Valid),  32'd0);
        chk("mid_rst_id",    32'(Pkt_ID),     32'd0);
        chk("mid_rst_addr",  32'(Pkt_Addr),   32'd0);
        chk("mid_rst_data",  32'(Pkt_Data),   32'd0);
        chk("mid_rst_match", 32'(Addr_Match), 32'd0);
        @(negedge Clk_S); S_Data_in = 1'b0; Rst_n = 1'b1;
        idle(2);
        @(negedge Clk_S); Pkt_Ready = 1'b1;
        push(DATA_C, 4'd1, 24'h123456);
        send_frame(DATA_C, 4'd1, 24'h123456, -1, 1'b0);
        idle(4);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
